// File: rtl/nec_ir_decoder_if.sv
// Bundles the IR receiver input with the decoded command/address and status strobes.
interface nec_ir_decoder_if;
    logic       ir_in;
    logic [7:0] ir_cmd;
    logic [7:0] ir_addr;
    logic       ir_valid;
    logic       ir_repeat;
    logic       frame_err;

    modport master (
        input  ir_in,
        output ir_cmd,
        output ir_addr,
        output ir_valid,
        output ir_repeat,
        output frame_err
    );

    modport slave (
        output ir_in,
        input  ir_cmd,
        input  ir_addr,
        input  ir_valid,
        input  ir_repeat,
        input  frame_err
    );
endinterface

// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder: measures mark/space durations in prescaled ticks and
// produces command/address bytes with valid, repeat and error strobes.
module nec_ir_decoder #(
    parameter int unsigned TICK_DIV      = 500,
    parameter bit          CHECK_ADDR    = 1'b1,
    parameter bit          IR_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    nec_ir_decoder_if.master   bus
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DUR_W = 11;
    localparam int unsigned CNT_W = 5;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] DUR_SAT  = '1;

    localparam logic [DUR_W-1:0] LEAD_MARK_LO  = DUR_W'(800);
    localparam logic [DUR_W-1:0] LEAD_MARK_HI  = DUR_W'(1000);
    localparam logic [DUR_W-1:0] LEAD_SPACE_LO = DUR_W'(400);
    localparam logic [DUR_W-1:0] LEAD_SPACE_HI = DUR_W'(500);
    localparam logic [DUR_W-1:0] RPT_SPACE_LO  = DUR_W'(180);
    localparam logic [DUR_W-1:0] RPT_SPACE_HI  = DUR_W'(270);
    localparam logic [DUR_W-1:0] SHORT_LO      = DUR_W'(40);
    localparam logic [DUR_W-1:0] SHORT_HI      = DUR_W'(72);
    localparam logic [DUR_W-1:0] ONE_LO        = DUR_W'(140);
    localparam logic [DUR_W-1:0] ONE_HI        = DUR_W'(200);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_RPT_MARK
    } state_e;

    logic             ir_s1_q, ir_s2_q, act_q;
    logic             act_c, rise_c, fall_c, tick_c;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DUR_W-1:0] dur_q, dur_d;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [31:0]      shift_q, shift_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       addr_q, addr_d;
    logic             have_frame_q, have_frame_d;
    logic             valid_q, valid_d;
    logic             repeat_q, repeat_d;
    logic             err_q, err_d;
    logic             err_c;
    logic             frame_ok_c;

    function automatic logic in_win(input logic [DUR_W-1:0] d,
                                    input logic [DUR_W-1:0] lo,
                                    input logic [DUR_W-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    // Synchronizer and edge register; reset to the idle (space) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_s1_q <= IR_ACTIVE_LOW;
            ir_s2_q <= IR_ACTIVE_LOW;
            act_q   <= 1'b0;
        end else begin
            ir_s1_q <= bus.ir_in;
            ir_s2_q <= ir_s1_q;
            act_q   <= act_c;
        end
    end

    assign act_c  = ir_s2_q ^ IR_ACTIVE_LOW;
    assign rise_c = act_c & ~act_q;
    assign fall_c = ~act_c & act_q;
    assign tick_c = (div_q == DIV_LAST);

    // Edges clear the duration counter and take priority over a coincident tick.
    always_comb begin
        div_d = tick_c ? '0 : div_q + DIV_W'(1);
        dur_d = dur_q;
        if (rise_c || fall_c) begin
            dur_d = '0;
        end else if (tick_c && (dur_q != DUR_SAT)) begin
            dur_d = dur_q + DUR_W'(1);
        end
    end

    assign frame_ok_c = (shift_q[23:16] == ~shift_q[31:24]) &&
                        (!CHECK_ADDR || (shift_q[7:0] == ~shift_q[15:8]));

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        have_frame_d = have_frame_q;
        valid_d      = 1'b0;
        repeat_d     = 1'b0;
        err_d        = 1'b0;
        err_c        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rise_c) state_d = S_LEAD_MARK;
            end
            S_LEAD_MARK: begin
                if (fall_c) begin
                    if (in_win(dur_q, LEAD_MARK_LO, LEAD_MARK_HI)) state_d = S_LEAD_SPACE;
                    else err_c = 1'b1;
                end else if (dur_q > LEAD_MARK_HI) begin
                    err_c = 1'b1;
                end
            end
            S_LEAD_SPACE: begin
                if (rise_c) begin
                    if (in_win(dur_q, LEAD_SPACE_LO, LEAD_SPACE_HI)) begin
                        state_d  = S_BIT_MARK;
                        bitcnt_d = '0;
                    end else if (in_win(dur_q, RPT_SPACE_LO, RPT_SPACE_HI)) begin
                        state_d = S_RPT_MARK;
                    end else begin
                        err_c = 1'b1;
                    end
                end else if (dur_q > LEAD_SPACE_HI) begin
                    err_c = 1'b1;
                end
            end
            S_BIT_MARK: begin
                if (fall_c) begin
                    if (in_win(dur_q, SHORT_LO, SHORT_HI)) state_d = S_BIT_SPACE;
                    else err_c = 1'b1;
                end else if (dur_q > SHORT_HI) begin
                    err_c = 1'b1;
                end
            end
            S_BIT_SPACE: begin
                if (rise_c) begin
                    if (in_win(dur_q, SHORT_LO, SHORT_HI) || in_win(dur_q, ONE_LO, ONE_HI)) begin
                        // LSB-first: the first bit received ends up in bit 0.
                        shift_d = {in_win(dur_q, ONE_LO, ONE_HI), shift_q[31:1]};
                        if (bitcnt_q == CNT_W'(31)) begin
                            state_d  = S_STOP_MARK;
                            bitcnt_d = '0;
                        end else begin
                            state_d  = S_BIT_MARK;
                            bitcnt_d = bitcnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_c = 1'b1;
                    end
                end else if (dur_q > ONE_HI) begin
                    err_c = 1'b1;
                end
            end
            S_STOP_MARK: begin
                if (fall_c) begin
                    if (in_win(dur_q, SHORT_LO, SHORT_HI)) begin
                        state_d = S_IDLE;
                        if (frame_ok_c) begin
                            cmd_d        = shift_q[23:16];
                            addr_d       = shift_q[7:0];
                            have_frame_d = 1'b1;
                            valid_d      = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_c = 1'b1;
                    end
                end else if (dur_q > SHORT_HI) begin
                    err_c = 1'b1;
                end
            end
            S_RPT_MARK: begin
                if (fall_c) begin
                    if (in_win(dur_q, SHORT_LO, SHORT_HI)) begin
                        state_d  = S_IDLE;
                        repeat_d = have_frame_q;
                    end else begin
                        err_c = 1'b1;
                    end
                end else if (dur_q > SHORT_HI) begin
                    err_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err_c) begin
            err_d    = 1'b1;
            state_d  = S_IDLE;
            bitcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            dur_q        <= '0;
            state_q      <= S_IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            have_frame_q <= 1'b0;
            valid_q      <= 1'b0;
            repeat_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            div_q        <= div_d;
            dur_q        <= dur_d;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            have_frame_q <= have_frame_d;
            valid_q      <= valid_d;
            repeat_q     <= repeat_d;
            err_q        <= err_d;
        end
    end

    assign bus.ir_cmd    = cmd_q;
    assign bus.ir_addr   = addr_q;
    assign bus.ir_valid  = valid_q;
    assign bus.ir_repeat = repeat_q;
    assign bus.frame_err = err_q;

endmodule
